// File: rtl/piano_pkg.sv
// piano_pkg: shared game state encoding and default sizing for the tile queue.
package piano_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  localparam int LANES = 4;
  localparam int DEPTH_DEF = 8;
  localparam int SCORE_MAX_DEF = 9999;
endpackage

// File: rtl/key_edge.sv
// key_edge: registered rising-edge detector turning held lane keys into one-cycle presses.
module key_edge
  import piano_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] key,
  output logic [LANES-1:0] press
);
  logic [LANES-1:0] prev_q, prev_d;
  always_comb prev_d = key;
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev_q <= '0;
    else prev_q <= prev_d;
  assign press = key & ~prev_q;
endmodule

// File: rtl/tile_queue.sv
// tile_queue: falling-tile shift queue with hit/miss scoring and IDLE/RUN/OVER game FSM.
module tile_queue
  import piano_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               spawn_tick,
  input  logic [2:0]         lane_in,
  input  logic [3:0]         key,
  output logic [DEPTH-1:0]   occ,
  output logic [2*DEPTH-1:0] lanes,
  output logic [3:0]         count,
  output logic [13:0]        score,
  output logic [1:0]         state,
  output logic               miss
);
  state_t             state_q, state_d;
  logic [2*DEPTH-1:0] slot_q, slot_d;
  logic [3:0]         count_q, count_d;
  logic [13:0]        score_q, score_d;
  logic               miss_q, miss_d;
  logic [3:0]         press;
  logic               run, hit, fail, push;
  logic [3:0]         idx;
  key_edge u_key_edge (.clk(clk), .rst(rst), .key(key), .press(press));
  always_comb begin
    run     = state_q == RUN;
    hit     = run && count_q != 4'd0 && press == (4'b1 << slot_q[1:0]);
    fail    = run && !hit && (press != 4'd0 || (spawn_tick && count_q == 4'(DEPTH)));
    push    = run && spawn_tick && !fail;
    // a same-cycle pop frees the slot below count, so the new tile lands one lower
    idx     = hit ? count_q - 4'd1 : count_q;
    state_d = state_q;
    count_d = count_q;
    score_d = score_q;
    slot_d  = slot_q;
    miss_d  = fail;
    occ     = '0;
    if (fail) state_d = OVER;
    else if (run) begin
      count_d = count_q + 4'(push) - 4'(hit);
      if (hit) score_d = score_q == 14'(SCORE_MAX) ? score_q : score_q + 14'd1;
      slot_d = hit ? slot_q >> 2 : slot_q;
      for (int k = 0; k < DEPTH; k++)
        if (push && idx == 4'(k)) slot_d[2*k +: 2] = lane_in[1:0];
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      score_d = '0;
      slot_d  = '0;
    end
    for (int k = 0; k < DEPTH; k++) occ[k] = 4'(k) < count_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      count_q <= '0;
      score_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  assign lanes = slot_q;
  assign count = count_q;
  assign score = score_q;
  assign state = state_q;
  assign miss  = miss_q;
endmodule

// File: tb/tb_tile_queue.sv
// tb_tile_queue: directed and random checks of tile_queue against a queue-based game model.
module tb_tile_queue;
  localparam int DEPTH = 8;
  localparam int SMAX  = 12;
  logic        clk = 0, rst = 0, start = 0, spawn_tick = 0;
  logic [2:0]  lane_in = '0;
  logic [3:0]  key = '0;
  logic [7:0]  occ;
  logic [15:0] lanes;
  logic [3:0]  count;
  logic [13:0] score;
  logic [1:0]  state;
  logic        miss;
  logic [44:0] obs;
  int checks = 0, errors = 0;
  int q[$];
  int m_score = 0, m_state = 0;
  logic [3:0] m_prev = '0;
  bit m_miss = 0;

  always #5 clk = ~clk;

  tile_queue #(.DEPTH(DEPTH), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .spawn_tick(spawn_tick), .lane_in(lane_in),
    .key(key), .occ(occ), .lanes(lanes), .count(count), .score(score), .state(state), .miss(miss)
  );

  assign obs = {state, score, count, occ, lanes, miss};

  function automatic logic [44:0] expv();
    logic [15:0] l = '0;
    logic [7:0]  o = '0;
    foreach (q[i]) begin
      l[2*i +: 2] = 2'(q[i]);
      o[i] = 1'b1;
    end
    return {2'(m_state), 14'(m_score), 4'(q.size()), o, l, m_miss};
  endfunction

  task automatic model_reset();
    q.delete();
    m_score = 0;
    m_state = 0;
    m_prev  = '0;
    m_miss  = 0;
  endtask

  task automatic cyc(input logic s, input logic sp, input logic [2:0] ln, input logic [3:0] k);
    logic [3:0] p;
    bit h;
    start = s; spawn_tick = sp; lane_in = ln; key = k;
    p = k & ~m_prev;
    m_prev = k;
    m_miss = 0;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (m_state == 2) begin
      if (s) begin q.delete(); m_score = 0; m_state = 1; end
    end else begin
      h = q.size() > 0 && p == 4'(1 << q[0]);
      if ((p != 0 && !h) || (sp && !h && q.size() == DEPTH)) begin
        m_state = 2;
        m_miss = 1;
      end else begin
        if (h) begin
          void'(q.pop_front());
          if (m_score < SMAX) m_score++;
        end
        if (sp) q.push_back(int'(ln[1:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (obs !== 45'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", obs); end
    rst = 1;
    cyc(0, 1, 3'd1, 4'b0000);
    cyc(0, 0, 3'd0, 4'b0000);
    checks++;
    if (state !== 2'd0 || count !== 4'd0) begin errors++; $display("FAIL idle_hold: state %0d count %0d exp 0 0", state, count); end
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL idle_model: got %h exp %h", obs, expv()); end
  endtask

  task automatic test_push();
    cyc(1, 0, 3'd0, 4'b0000);
    cyc(0, 1, 3'd2, 4'b0000);
    cyc(0, 1, 3'd0, 4'b0000);
    cyc(0, 1, 3'd3, 4'b0000);
    checks++;
    if (count !== 4'd3 || lanes[5:0] !== 6'b110010 || occ !== 8'h07) begin
      errors++; $display("FAIL push_three: count %0d lanes %b occ %b exp 3 110010 00000111", count, lanes[5:0], occ);
    end
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL push_model: got %h exp %h", obs, expv()); end
  endtask

  task automatic test_hit();
    cyc(0, 0, 3'd0, 4'b0100);
    checks++;
    if (score !== 14'd1 || lanes[1:0] !== 2'd0 || count !== 4'd2) begin
      errors++; $display("FAIL hit_pop: score %0d head %0d count %0d exp 1 0 2", score, lanes[1:0], count);
    end
    cyc(0, 0, 3'd0, 4'b0000);
    repeat (5) cyc(0, 0, 3'd0, 4'b0001);
    checks++;
    if (score !== 14'd2 || count !== 4'd1 || state !== 2'd1) begin
      errors++; $display("FAIL held_key: score %0d count %0d state %0d exp 2 1 1", score, count, state);
    end
    cyc(0, 0, 3'd0, 4'b0000);
  endtask

  task automatic test_miss();
    cyc(0, 0, 3'd0, 4'b1000);
    cyc(0, 0, 3'd0, 4'b0000);
    cyc(0, 1, 3'd1, 4'b0000);
    cyc(0, 1, 3'd2, 4'b1000);
    checks++;
    if (state !== 2'd2 || miss !== 1'b1 || count !== 4'd1 || score !== 14'd3) begin
      errors++; $display("FAIL wrong_lane: state %0d miss %0d count %0d score %0d exp 2 1 1 3", state, miss, count, score);
    end
    cyc(0, 1, 3'd0, 4'b0000);
    checks++;
    if (miss !== 1'b0 || count !== 4'd1 || obs !== expv()) begin
      errors++; $display("FAIL over_frozen: got %h exp %h", obs, expv());
    end
    cyc(1, 0, 3'd0, 4'b0000);
    checks++;
    if (state !== 2'd1 || count !== 4'd0 || score !== 14'd0) begin
      errors++; $display("FAIL restart: state %0d count %0d score %0d exp 1 0 0", state, count, score);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] nl;
    repeat (DEPTH) cyc(0, 1, 3'($urandom_range(0, 7)), 4'b0000);
    checks++;
    if (count !== 4'd8 || occ !== 8'hff || obs !== expv()) begin
      errors++; $display("FAIL fill: got %h exp %h", obs, expv());
    end
    cyc(0, 1, 3'd3, 4'b0000);
    checks++;
    if (state !== 2'd2 || miss !== 1'b1 || count !== 4'd8) begin
      errors++; $display("FAIL overflow: state %0d miss %0d count %0d exp 2 1 8", state, miss, count);
    end
    cyc(1, 0, 3'd0, 4'b0000);
    repeat (DEPTH) cyc(0, 1, 3'($urandom_range(0, 3)), 4'b0000);
    nl = 3'($urandom_range(0, 3));
    cyc(0, 1, nl, 4'(1 << q[0]));
    checks++;
    if (state !== 2'd1 || count !== 4'd8 || lanes[15:14] !== nl[1:0] || score !== 14'd1) begin
      errors++; $display("FAIL full_hit_push: state %0d count %0d top %0d score %0d exp 1 8 %0d 1", state, count, lanes[15:14], score, nl[1:0]);
    end
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL full_hit_model: got %h exp %h", obs, expv()); end
    cyc(0, 0, 3'd0, 4'b0000);
  endtask

  task automatic test_multi();
    cyc(0, 0, 3'd0, 4'b1111);
    cyc(1, 0, 3'd0, 4'b0000);
    cyc(0, 1, 3'd0, 4'b0000);
    cyc(0, 0, 3'd0, 4'b0011);
    checks++;
    if (state !== 2'd2 || miss !== 1'b1 || count !== 4'd1) begin
      errors++; $display("FAIL two_keys: state %0d miss %0d count %0d exp 2 1 1", state, miss, count);
    end
    cyc(1, 0, 3'd0, 4'b0000);
    cyc(0, 0, 3'd0, 4'b0100);
    checks++;
    if (state !== 2'd2 || miss !== 1'b1 || count !== 4'd0 || score !== 14'd0) begin
      errors++; $display("FAIL empty_press: state %0d miss %0d count %0d score %0d exp 2 1 0 0", state, miss, count, score);
    end
    cyc(1, 0, 3'd0, 4'b0000);
  endtask

  task automatic test_saturate();
    logic [2:0] ln;
    repeat (SMAX + 3) begin
      ln = 3'($urandom_range(0, 3));
      cyc(0, 1, ln, 4'b0000);
      cyc(0, 0, 3'd0, 4'(1 << ln));
      cyc(0, 0, 3'd0, 4'b0000);
    end
    checks++;
    if (score !== 14'(SMAX) || state !== 2'd1 || count !== 4'd0) begin
      errors++; $display("FAIL saturate: score %0d state %0d count %0d exp %0d 1 0", score, state, count, SMAX);
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    int r;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      k = r < 55 ? 4'd0 : (r < 85 && q.size() > 0) ? 4'(1 << q[0]) : 4'($urandom);
      cyc(m_state == 2 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0),
          $urandom_range(0, 2) == 0, 3'($urandom), k);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random_%0d: got %h exp %h", i, obs, expv()); end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ln;
    cyc(0, 0, 3'd0, 4'b0000);
    if (m_state == 1) cyc(0, 0, 3'd0, 4'b1111);
    cyc(1, 0, 3'd0, 4'b0000);
    repeat (7) begin
      ln = 3'($urandom_range(0, 3));
      cyc(0, 1, ln, 4'b0000);
      cyc(0, 0, 3'd0, 4'(1 << ln));
      cyc(0, 0, 3'd0, 4'b0000);
    end
    repeat (5) cyc(0, 1, 3'($urandom_range(0, 3)), 4'b0000);
    checks++;
    if (count !== 4'd5 || score !== 14'd7 || state !== 2'd1) begin
      errors++; $display("FAIL pre_reset: count %0d score %0d state %0d exp 5 7 1", count, score, state);
    end
    #3 rst = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== 45'd0) begin errors++; $display("FAIL async_reset: got %h exp 0", obs); end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 45'd0) begin errors++; $display("FAIL reset_held: got %h exp 0", obs); end
    rst = 1;
    cyc(0, 1, 3'd1, 4'b0010);
    checks++;
    if (state !== 2'd0 || count !== 4'd0 || miss !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: state %0d count %0d miss %0d exp 0 0 0", state, count, miss);
    end
    cyc(1, 0, 3'd0, 4'b0000);
    checks++;
    if (obs !== expv() || state !== 2'd1) begin errors++; $display("FAIL post_reset_start: got %h exp %h", obs, expv()); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_hit();
    test_miss();
    test_overflow();
    test_multi();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
